// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port round-robin arbiter/sequencer in front of a shared combinational 4-bit ALU
// Ports:
//   clk, reset (async, active-low)
//   req0/req1, a0/b0/op0, a1/b1/op1    requester inputs; gnt0/gnt1 combinational grants
//   alu_a/alu_b/alu_op/alu_l           registered ALU operands/opcode
//   alu_r/alu_zero/alu_carry/alu_sign  ALU result and flags
//   rsp_valid/rsp_ready                response handshake
//   rsp_id/rsp_r/rsp_zero/rsp_carry/rsp_sign  registered response
//   busy                               high outside IDLE
module alu_arbiter #(
  parameter logic PRIO_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  input  logic [2:0] op0,
  input  logic [2:0] op1,
  output logic       gnt0,
  output logic       gnt1,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_op,
  output logic       alu_l,
  input  logic [3:0] alu_r,
  input  logic       alu_zero,
  input  logic       alu_carry,
  input  logic       alu_sign,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [3:0] rsp_r,
  output logic       rsp_zero,
  output logic       rsp_carry,
  output logic       rsp_sign,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state;
  logic   last;
  logic   idle;
  // Grants are gated by reset so nothing is offered while reset is held.
  assign idle = reset && state == IDLE;
  // On a tie the requester not served last wins.
  assign gnt0 = idle && req0 && (!req1 || last);
  assign gnt1 = idle && req1 && (!req0 || !last);
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state     <= IDLE;
      last      <= ~PRIO_INIT;
      alu_a     <= 4'd0;
      alu_b     <= 4'd0;
      alu_op    <= 2'd0;
      alu_l     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_r     <= 4'd0;
      rsp_zero  <= 1'b0;
      rsp_carry <= 1'b0;
      rsp_sign  <= 1'b0;
    end else
      case (state)
        IDLE:
          if (gnt0 || gnt1) begin
            alu_a           <= gnt1 ? a1 : a0;
            alu_b           <= gnt1 ? b1 : b0;
            {alu_l, alu_op} <= gnt1 ? op1 : op0;
            rsp_id          <= gnt1;
            last            <= gnt1;
            state           <= EXEC;
          end
        EXEC: begin
          rsp_r     <= alu_r;
          rsp_zero  <= alu_zero;
          rsp_carry <= alu_carry;
          rsp_sign  <= alu_sign;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP:
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter driving a behavioural 4-bit ALU
module tb_alu_arbiter;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [3:0] a0 = 4'd0, b0 = 4'd0, a1 = 4'd0, b1 = 4'd0;
  logic [2:0] op0 = 3'd0, op1 = 3'd0;
  logic       gnt0, gnt1;
  logic [3:0] alu_a, alu_b, alu_r;
  logic [1:0] alu_op;
  logic       alu_l, alu_zero, alu_carry, alu_sign;
  logic       rsp_valid, rsp_ready = 1'b1, rsp_id;
  logic [3:0] rsp_r;
  logic       rsp_zero, rsp_carry, rsp_sign, busy;
  logic [4:0] s;
  int         total = 0, bad = 0, cyc = 0;
  logic [7:0] exp_q[$];

  alu_arbiter #(.PRIO_INIT(1'b0)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .op0(op0), .op1(op1),
    .gnt0(gnt0), .gnt1(gnt1), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_l(alu_l),
    .alu_r(alu_r), .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_sign(alu_sign),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_r(rsp_r),
    .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .rsp_sign(rsp_sign), .busy(busy)
  );

  // Behavioural ALU: l=0 arithmetic {A, B, A+B, A-B}, l=1 logic {AND, OR, XOR, NOT A}.
  always_comb begin
    s = 5'd0;
    case ({alu_l, alu_op})
      3'b000: s = {1'b0, alu_a};
      3'b001: s = {1'b0, alu_b};
      3'b010: s = {1'b0, alu_a} + {1'b0, alu_b};
      3'b011: s = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
      3'b100: s = {1'b0, alu_a & alu_b};
      3'b101: s = {1'b0, alu_a | alu_b};
      3'b110: s = {1'b0, alu_a ^ alu_b};
      default: s = {1'b0, ~alu_a};
    endcase
  end
  assign alu_r     = s[3:0];
  assign alu_carry = s[4];
  assign alu_zero  = s[3:0] == 4'd0;
  assign alu_sign  = s[3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: one pop per response, on the cycle the handshake is about to complete.
  always @(negedge clk)
    if (reset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: got id=%0d r=%h want none", rsp_id, rsp_r);
      end else
        chk("rsp", {rsp_id, rsp_r, rsp_zero, rsp_carry, rsp_sign}, exp_q.pop_front());
    end

  task automatic raise(input bit n, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    if (n) begin
      req1 = 1'b1; a1 = a; b1 = b; op1 = op;
    end else begin
      req0 = 1'b1; a0 = a; b0 = b; op0 = op;
    end
  endtask

  task automatic wait_gnt(input bit n);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (n ? gnt1 : gnt0) break;
    end
    chk(n ? "gnt1" : "gnt0", {6'd0, gnt1, gnt0}, n ? 8'd2 : 8'd1);
  endtask

  task automatic do_req(input bit n, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                        input logic [3:0] r, input logic z, input logic c, input logic sg);
    exp_q.push_back({n, r, z, c, sg});
    @(posedge clk); #1;
    raise(n, a, b, op);
    wait_gnt(n);
    @(posedge clk); #1;
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    chk("exec_operands", {alu_a, alu_b}, {a, b});
    chk("exec_op", {3'd0, alu_l, alu_op, busy, rsp_valid}, {3'd0, op, 1'b1, 1'b0});
    @(negedge clk);
    chk("resp_valid", {6'd0, busy, rsp_valid}, 8'd3);
    @(negedge clk);
    chk("back_idle", {6'd0, busy, rsp_valid}, 8'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int ids[$], cys[$];
    // Reset held with a pending request: nothing granted, everything cleared.
    req0 = 1'b1; a0 = 4'd3; b0 = 4'd4; op0 = 3'b010;
    repeat (2) @(negedge clk);
    chk("reset_ctl", {gnt0, gnt1, busy, rsp_valid, rsp_id, rsp_zero, rsp_carry, rsp_sign}, 8'd0);
    chk("reset_alu", {alu_a, alu_b}, 8'd0);
    chk("reset_rsp", {1'b0, alu_l, alu_op, rsp_r}, 8'd0);
    req0 = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("idle_no_req", {5'd0, gnt0, gnt1, busy}, 8'd0);
    // Directed singles.
    do_req(1'b0, 4'd3, 4'd4, 3'b010, 4'd7, 1'b0, 1'b0, 1'b0);
    do_req(1'b1, 4'd2, 4'd5, 3'b011, 4'b1101, 1'b0, 1'b0, 1'b1);
    // Round-robin with both held; last served is requester 1.
    exp_q.push_back({1'b0, 4'd2, 1'b0, 1'b0, 1'b0});
    exp_q.push_back({1'b1, 4'd0, 1'b1, 1'b1, 1'b0});
    exp_q.push_back({1'b0, 4'd2, 1'b0, 1'b0, 1'b0});
    exp_q.push_back({1'b1, 4'd0, 1'b1, 1'b1, 1'b0});
    @(posedge clk); #1;
    raise(1'b0, 4'd1, 4'd1, 3'b010);
    raise(1'b1, 4'd7, 4'd9, 3'b010);
    for (int i = 0; i < 20 && ids.size() < 4; i++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        ids.push_back(int'(gnt1));
        cys.push_back(cyc);
      end
    end
    @(posedge clk); #1;
    req0 = 1'b0;
    req1 = 1'b0;
    chk("rr_count", 8'(ids.size()), 8'd4);
    for (int k = 0; k < ids.size(); k++) chk("rr_order", 8'(ids[k]), 8'(k % 2));
    for (int k = 1; k < cys.size(); k++) chk("rr_spacing", 8'(cys[k] - cys[k-1]), 8'd3);
    repeat (3) @(negedge clk);
    // More patterns through the logic half of the opcode space.
    do_req(1'b1, 4'hA, 4'h5, 3'b110, 4'hF, 1'b0, 1'b0, 1'b1);
    do_req(1'b0, 4'hC, 4'h3, 3'b100, 4'h0, 1'b1, 1'b0, 1'b0);
    // Backpressure: response held, pending req1 must wait.
    exp_q.push_back({1'b0, 4'd2, 1'b0, 1'b1, 1'b0});
    exp_q.push_back({1'b1, 4'hF, 1'b0, 1'b0, 1'b1});
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    raise(1'b0, 4'd5, 4'd3, 3'b011);
    wait_gnt(1'b0);
    @(posedge clk); #1;
    req0 = 1'b0;
    raise(1'b1, 4'hF, 4'hF, 3'b100);
    @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold", {rsp_valid, gnt1, busy, rsp_id, rsp_r}, {1'b1, 1'b0, 1'b1, 1'b0, 4'd2});
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("no_gnt_in_resp", {6'd0, gnt1, rsp_valid}, 8'd1);
    wait_gnt(1'b1);
    @(posedge clk); #1;
    req1 = 1'b0;
    repeat (3) @(negedge clk);
    // Reset during EXEC discards the operation.
    @(posedge clk); #1;
    raise(1'b0, 4'd1, 4'd2, 3'b010);
    wait_gnt(1'b0);
    @(posedge clk); #1;
    req0 = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("mid_reset_ctl", {4'd0, rsp_valid, busy, gnt0, gnt1}, 8'd0);
    chk("mid_reset_data", {alu_a, rsp_r}, 8'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("no_rsp_after_reset", {6'd0, rsp_valid, busy}, 8'd0);
    end
    exp_q.push_back({1'b0, 4'd0, 1'b1, 1'b1, 1'b0});
    @(posedge clk); #1;
    raise(1'b0, 4'd9, 4'd7, 3'b010);
    raise(1'b1, 4'd3, 4'd3, 3'b010);
    wait_gnt(1'b0);
    @(posedge clk); #1;
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (4) @(negedge clk);
    chk("queue_empty", 8'(exp_q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
